// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI write/read arbiters:
// the idle byte-enable code and the arbiter state encoding.
`default_nettype none

package axi_arb_pkg;

  localparam logic [3:0] WRITE_NONE = 4'b1111;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the winner is the first pending index
// at or after rr_ptr, wrapping modulo NREQ.
`default_nettype none

module rr_pick #(
  parameter  int NREQ = 2,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   rr_ptr,
  output logic            any_valid,
  output logic [GW-1:0]   winner
);

  logic [GW:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    any_valid = |pending;
    winner    = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (idx >= (GW + 1)'(NREQ)) begin
        idx = idx - (GW + 1)'(NREQ);
      end
      if (pending[idx[GW-1:0]]) begin
        winner = idx[GW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write master between NREQ requesters;
// the granted request is registered and held until the master drops stall.
`default_nettype none

module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ*32-1:0] req_address,
  input  logic [NREQ*4-1:0]  req_write,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]  req_stall,
  output logic [31:0]      m_address,
  output logic [3:0]       m_write,
  output logic [31:0]      m_data,
  input  logic             m_stall,
  output logic [GW-1:0]    grant_id,
  output logic             busy
);

  arb_state_t      state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   next_ptr;
  logic [NREQ-1:0] pending;
  logic            any_valid;
  logic            done;

  logic [31:0]     cap_address;
  logic [3:0]      cap_write;
  logic [31:0]     cap_data;
  logic [31:0]     sel_address;
  logic [3:0]      sel_write;
  logic [31:0]     sel_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_pending
    assign pending[i]   = (req_write[4*i +: 4] != WRITE_NONE);
    assign req_stall[i] = pending[i] && !(done && (grant_id == GW'(i)));
  end

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .pending  (pending),
    .rr_ptr   (rr_ptr),
    .any_valid(any_valid),
    .winner   (winner)
  );

  always_comb begin
    sel_address = '0;
    sel_write   = WRITE_NONE;
    sel_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == GW'(i)) begin
        sel_address = req_address[32*i +: 32];
        sel_write   = req_write[4*i +: 4];
        sel_data    = req_data[32*i +: 32];
      end
    end
  end

  assign done = (state == ARB_BUSY) && !m_stall;

  // Explicit compare keeps the wrap correct for non-power-of-two NREQ.
  assign next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cap_address <= '0;
      cap_write   <= WRITE_NONE;
      cap_data    <= '0;
    end else if (state == ARB_IDLE) begin
      if (any_valid) begin
        cap_address <= sel_address;
        cap_write   <= sel_write;
        cap_data    <= sel_data;
        grant_id    <= winner;
        state       <= ARB_BUSY;
      end
    end else begin
      if (!m_stall) begin
        rr_ptr <= next_ptr;
        state  <= ARB_IDLE;
      end
    end
  end

  // The IDLE bubble keeps the master from reissuing the finished request.
  assign m_write   = (state == ARB_BUSY) ? cap_write : WRITE_NONE;
  assign m_address = cap_address;
  assign m_data    = cap_data;
  assign busy      = (state == ARB_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter with three requesters.
`default_nettype none

module tb_axi_write_arbiter;

  localparam int NREQ = 3;
  localparam int GW   = 2;
  localparam logic [3:0] NONE = 4'b1111;

  logic              clk;
  logic              rst;
  logic [NREQ*32-1:0] req_address;
  logic [NREQ*4-1:0]  req_write;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_stall;
  logic [31:0]       m_address;
  logic [3:0]        m_write;
  logic [31:0]       m_data;
  logic              m_stall;
  logic [GW-1:0]     grant_id;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int ver [NREQ];

  axi_write_arbiter #(
    .NREQ(NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_address(req_address),
    .req_write  (req_write),
    .req_data   (req_data),
    .req_stall  (req_stall),
    .m_address  (m_address),
    .m_write    (m_write),
    .m_data     (m_data),
    .m_stall    (m_stall),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d);
    req_address[32*i +: 32] = a;
    req_write[4*i +: 4]     = w;
    req_data[32*i +: 32]    = d;
  endtask

  function automatic logic [31:0] cdata(input int i, input int v);
    return 32'hC000_0000 | 32'(i << 8) | 32'(v);
  endfunction

  initial begin
    rst         = 1'b0;
    req_address = '0;
    req_data    = '0;
    req_write   = {NREQ{NONE}};
    m_stall     = 1'b1;
    for (int i = 0; i < NREQ; i++) ver[i] = 0;

    // Reset values
    #3;
    chk("rst_m_write", 32'(m_write), 32'(NONE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_address", m_address, 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_req_stall", 32'(req_stall), 32'd0);
    step();
    step();
    rst = 1'b1;

    // Single request on requester 0
    set_req(0, 32'h0001_0004, 4'b0000, 32'hDEAD_BEEF);
    #1;
    chk("t0_m_write", 32'(m_write), 32'(NONE));
    chk("t0_req_stall", 32'(req_stall), 32'b001);
    step();
    chk("t1_m_write", 32'(m_write), 32'(4'b0000));
    chk("t1_m_address", m_address, 32'h0001_0004);
    chk("t1_m_data", m_data, 32'hDEAD_BEEF);
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_stall", 32'(req_stall), 32'b001);
    step();
    chk("t2_req_stall", 32'(req_stall), 32'b001);
    chk("t2_m_write", 32'(m_write), 32'(4'b0000));
    step();
    m_stall = 1'b0;
    #1;
    chk("t3_req_stall", 32'(req_stall), 32'b000);
    chk("t3_busy", 32'(busy), 32'd1);
    step();
    set_req(0, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;
    #1;
    chk("t4_m_write", 32'(m_write), 32'(NONE));
    chk("t4_busy", 32'(busy), 32'd0);

    // Requester 2 alone from rr_ptr=1; completion wraps rr_ptr to 0
    set_req(2, 32'h2000_0000, 4'b1110, 32'h2222_0001);
    step();
    chk("wrap_grant", 32'(grant_id), 32'd2);
    chk("wrap_m_write", 32'(m_write), 32'(4'b1110));
    chk("wrap_m_address", m_address, 32'h2000_0000);
    m_stall = 1'b0;
    #1;
    chk("wrap_req_stall", 32'(req_stall), 32'b000);
    step();
    set_req(2, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;
    #1;
    chk("wrap_idle", 32'(busy), 32'd0);

    // Simultaneous req0 + req1 with rr_ptr=0
    set_req(0, 32'h0000_0A00, 4'b0000, 32'hA0A0_A0A0);
    set_req(1, 32'h0000_0B00, 4'b0011, 32'hB1B1_B1B1);
    #1;
    chk("sim_req_stall0", 32'(req_stall), 32'b011);
    step();
    chk("sim_grant0", 32'(grant_id), 32'd0);
    chk("sim_m_address0", m_address, 32'h0000_0A00);
    chk("sim_req_stall1", 32'(req_stall), 32'b011);
    m_stall = 1'b0;
    #1;
    chk("sim_done0_stall", 32'(req_stall), 32'b010);
    step();
    set_req(0, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;
    #1;
    chk("sim_bubble_m_write", 32'(m_write), 32'(NONE));
    chk("sim_bubble_stall", 32'(req_stall), 32'b010);
    step();
    chk("sim_grant1", 32'(grant_id), 32'd1);
    chk("sim_m_write1", 32'(m_write), 32'(4'b0011));
    chk("sim_m_data1", m_data, 32'hB1B1_B1B1);
    m_stall = 1'b0;
    step();
    set_req(1, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;

    // Requester 2 back-to-back: capture, busy/done, bubble, next capture
    set_req(2, 32'h2000_0100, 4'b1100, 32'h2222_000A);
    step();
    chk("b2b_grant_a", 32'(grant_id), 32'd2);
    chk("b2b_data_a", m_data, 32'h2222_000A);
    m_stall = 1'b0;
    step();
    set_req(2, 32'h2000_0104, 4'b1000, 32'h2222_000B);
    m_stall = 1'b1;
    #1;
    chk("b2b_bubble", 32'(m_write), 32'(NONE));
    step();
    chk("b2b_grant_b", 32'(grant_id), 32'd2);
    chk("b2b_m_write_b", 32'(m_write), 32'(4'b1000));
    chk("b2b_data_b", m_data, 32'h2222_000B);
    m_stall = 1'b0;
    step();
    set_req(2, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;

    // Continuous contention from rr_ptr=0
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 4'b0000, cdata(i, ver[i]));
    for (int g = 0; g < 9; g++) begin
      #1;
      chk("cont_idle", 32'(busy), 32'd0);
      step();
      chk("cont_grant", 32'(grant_id), 32'(g % NREQ));
      chk("cont_data", m_data, cdata(g % NREQ, ver[g % NREQ]));
      m_stall = 1'b0;
      step();
      ver[g % NREQ]++;
      set_req(g % NREQ, 32'(g % NREQ), 4'b0000, cdata(g % NREQ, ver[g % NREQ]));
      m_stall = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, NONE, 32'h0);

    // DECERR retry: stall held for 20 cycles in BUSY
    set_req(0, 32'h0000_1000, 4'b0000, 32'h0D0D_0D0D);
    set_req(1, 32'h0000_2000, 4'b0001, 32'h1111_2222);
    step();
    for (int c = 0; c < 20; c++) begin
      chk("decerr_busy", 32'(busy), 32'd1);
      chk("decerr_m_address", m_address, 32'h0000_1000);
      chk("decerr_req_stall", 32'(req_stall), 32'b011);
      step();
    end
    m_stall = 1'b0;
    #1;
    chk("decerr_done_stall", 32'(req_stall), 32'b010);
    step();
    set_req(0, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;
    #1;
    chk("decerr_bubble", 32'(m_write), 32'(NONE));
    step();
    chk("decerr_next_grant", 32'(grant_id), 32'd1);
    chk("decerr_next_addr", m_address, 32'h0000_2000);
    m_stall = 1'b0;
    step();
    set_req(1, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;

    // Reset mid-BUSY from rr_ptr=2
    set_req(1, 32'h3000_0010, 4'b0000, 32'hAAAA_0001);
    set_req(2, 32'h3000_0020, 4'b0000, 32'hBBBB_0002);
    step();
    chk("mrst_pre_grant", 32'(grant_id), 32'd2);
    chk("mrst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_m_write", 32'(m_write), 32'(NONE));
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    chk("mrst_m_address", m_address, 32'h0);
    chk("mrst_m_data", m_data, 32'h0);
    chk("mrst_req_stall", 32'(req_stall), 32'b110);
    step();
    chk("mrst_held", 32'(busy), 32'd0);
    rst = 1'b1;
    step();
    chk("mrst_after_grant", 32'(grant_id), 32'd1);
    chk("mrst_after_addr", m_address, 32'h3000_0010);
    m_stall = 1'b0;
    step();
    set_req(1, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;
    step();
    chk("mrst_then_grant2", 32'(grant_id), 32'd2);
    m_stall = 1'b0;
    step();
    set_req(2, 32'h0, NONE, 32'h0);
    m_stall = 1'b1;

    // Granted requester withdraws mid-BUSY
    set_req(0, 32'h4000_0000, 4'b0101, 32'h5555_AAAA);
    step();
    chk("wd_grant", 32'(grant_id), 32'd0);
    set_req(0, 32'h0, NONE, 32'h0);
    #1;
    chk("wd_req_stall", 32'(req_stall), 32'b000);
    chk("wd_m_write", 32'(m_write), 32'(4'b0101));
    chk("wd_m_address", m_address, 32'h4000_0000);
    step();
    chk("wd_m_write_hold", 32'(m_write), 32'(4'b0101));
    chk("wd_busy_hold", 32'(busy), 32'd1);
    m_stall = 1'b0;
    step();
    m_stall = 1'b1;
    #1;
    chk("wd_done_m_write", 32'(m_write), 32'(NONE));
    chk("wd_done_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("wd_stays_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
